fp_window_buffer: RTL

// - Front-end stage directly upstream of the fixed-point processing element (first conv layer).
// - Accepts a raster-order stream of multi-channel fixed-point pixels and buffers WIN_H-1 image rows.
// - Emits one flattened WIN_H x WIN_W x D window, on a stride grid, on the PE's data_in bus.
// - out_valid drives the PE's in_en.

---
 rtl/fp_window_buffer_pkg.sv | 19 +
 rtl/fp_line_delay.sv | 35 +++
 rtl/fp_window_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fp_window_buffer_pkg.sv
// fp_window_buffer_pkg
//   Shared types and helpers for the window buffer slice.
//   - fsm_state_t : FILL (upper rows of a frame still being buffered) / STREAM
//   - on_grid()   : true when a position lies on or after its origin and
//                   falls on the stride grid that starts at that origin
package fp_window_buffer_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } fsm_state_t;

  function automatic logic on_grid(input int unsigned pos,
                                   input int unsigned origin,
                                   input int unsigned step);
    return (pos >= origin) && (((pos - origin) % step) == 0);
  endfunction

endpackage

// File: rtl/fp_line_delay.sv
// fp_line_delay
//   Fixed-depth pixel delay line. Each enabled cycle shifts one pixel in;
//   dout is the pixel that entered DEPTH enables earlier, which is the
//   pixel one image row above when DEPTH equals the image width.
//   Storage is never cleared: consumers only look at it once it has been
//   refilled with valid data.
//   Ports:
//     clk  in   clock
//     en   in   shift enable (pixel accepted)
//     din  in   WIDTH-bit pixel entering the line
//     dout out  WIDTH-bit pixel leaving the line
module fp_line_delay #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        mem[k] <= mem[k-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/fp_window_buffer.sv
// fp_window_buffer
//   Raster-order pixel stream in, WIN_H x WIN_W x D windows out on a stride
//   grid, feeding the first conv layer's processing element.
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset
//     in_valid   in   pixel present
//     in_ready   out  stage accepts pixel (low during reset or while a
//                     window is held for the consumer)
//     in_pixel   in   D samples, channel d at [d*DATA_WIDTH +: DATA_WIDTH]
//     out_valid  out  window present (PE in_en)
//     out_ready  in   consumer takes window
//     data_out   out  flattened window, element (i,j,d) at
//                     [((i*WIN_W+j)*D+d)*DATA_WIDTH +: DATA_WIDTH]
//     win_row    out  image row of window top-left
//     win_col    out  image col of window top-left
//     frame_done out  one-cycle pulse after the last pixel of a frame
module fp_window_buffer
  import fp_window_buffer_pkg::*;
#(
  parameter  int D          = 3,
  parameter  int DATA_WIDTH = 8,
  parameter  int IMG_H      = 16,
  parameter  int IMG_W      = 16,
  parameter  int WIN_H      = 4,
  parameter  int WIN_W      = 4,
  parameter  int STEP_H     = 2,
  parameter  int STEP_W     = 2,
  localparam int PIXEL_BITS  = D * DATA_WIDTH,
  localparam int WINDOW_BITS = WIN_H * WIN_W * PIXEL_BITS,
  localparam int ROW_CW      = $clog2(IMG_H),
  localparam int COL_CW      = $clog2(IMG_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_BITS-1:0]  in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WINDOW_BITS-1:0] data_out,
  output logic [ROW_CW-1:0]      win_row,
  output logic [COL_CW-1:0]      win_col,
  output logic                   frame_done
);

  fsm_state_t state, state_nxt;
  logic [ROW_CW-1:0] row_cnt;
  logic [COL_CW-1:0] col_cnt;
  logic accept, last_col, frame_end, row_live;

  logic [PIXEL_BITS-1:0] tap [WIN_H];
  logic [PIXEL_BITS-1:0] sr  [WIN_H][WIN_W];
  logic [PIXEL_BITS-1:0] nxt [WIN_H][WIN_W];

  logic                   vld_p0;
  logic [WINDOW_BITS-1:0] win_p0;

  logic                   vld_p1;
  logic                   done_p1;
  logic [WINDOW_BITS-1:0] win_p1;
  logic [ROW_CW-1:0]      row_p1;
  logic [COL_CW-1:0]      col_p1;

  // No skid buffer: a held window blocks input; rst blocks it immediately.
  assign in_ready  = ~rst & (~vld_p1 | out_ready);
  assign accept    = in_valid & in_ready;
  assign last_col  = (col_cnt == COL_CW'(IMG_W - 1));
  assign frame_end = last_col & (row_cnt == ROW_CW'(IMG_H - 1));

  // tap[k] is the pixel k rows above the incoming one, same column.
  assign tap[0] = in_pixel;

  for (genvar k = 0; k < WIN_H - 1; k++) begin : g_line
    fp_line_delay #(
      .WIDTH(PIXEL_BITS),
      .DEPTH(IMG_W)
    ) u_line (
      .clk (clk),
      .en  (accept),
      .din (tap[k]),
      .dout(tap[k+1])
    );
  end

  // Window contents once the current pixel is shifted in: every row moves
  // one column left and takes its tap in the rightmost column. The top
  // window row is the oldest tap.
  always_comb begin
    win_p0 = '0;
    for (int i = 0; i < WIN_H; i++) begin
      for (int j = 0; j < WIN_W - 1; j++) begin
        nxt[i][j] = sr[i][j+1];
      end
      nxt[i][WIN_W-1] = tap[WIN_H-1-i];
      for (int j = 0; j < WIN_W; j++) begin
        win_p0[(i*WIN_W + j)*PIXEL_BITS +: PIXEL_BITS] = nxt[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sr <= nxt;
    end
  end

  // Row gating by the FSM keeps the first WIN_H-1 rows of every frame,
  // whose line taps still hold the previous frame, from triggering; the
  // column guard keeps windows from spanning two image rows.
  assign row_live = (state == STREAM) | (row_cnt == ROW_CW'(WIN_H - 1));
  assign vld_p0   = accept & row_live
                  & on_grid(32'(row_cnt), WIN_H - 1, STEP_H)
                  & on_grid(32'(col_cnt), WIN_W - 1, STEP_W);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && row_cnt == ROW_CW'(WIN_H - 1) && !frame_end) state_nxt = STREAM;
      STREAM:  if (accept && frame_end) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= frame_end ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // ---- stage p0 -> p1: output register, held until the consumer takes it ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      win_p1  <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
    end else begin
      done_p1 <= accept & frame_end;
      if (vld_p0) begin
        vld_p1 <= 1'b1;
        win_p1 <= win_p0;
        row_p1 <= row_cnt - ROW_CW'(WIN_H - 1);
        col_p1 <= col_cnt - COL_CW'(WIN_W - 1);
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid  = vld_p1;
  assign data_out   = win_p1;
  assign win_row    = row_p1;
  assign win_col    = col_p1;
  assign frame_done = done_p1;

endmodule
